sect_pt_mul_word_if: RTL and testbench

//   Word-serial front/back end for sect_pt_mul (e.g. the sect571r1 point multiplier instance).

---
 rtl/sect_pt_mul_word_if.sv | 153 +++++++++++++++
 tb/tb_sect_pt_mul_word_if.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sect_pt_mul_word_if.sv
// Word-serial stream adapter for the sect_pt_mul point multiplier: assembles scalar d from
// W-bit input words, runs one multiplication, then streams x and y back out as W-bit words.
module sect_pt_mul_word_if #(
  parameter int M = 571,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         out_inf,
  output logic         busy,
  output logic         pm_start,
  output logic [M-1:0] pm_d,
  input  logic         pm_done,
  input  logic [M-1:0] pm_x,
  input  logic [M-1:0] pm_y
);

  localparam int NW = (M + W - 1) / W;
  localparam int PW = NW * W;
  localparam int CW = $clog2(2 * NW);

  // Keeps only the M field bits of a word-padded operand.
  localparam logic [PW-1:0] FIELD_MASK = {PW{1'b1}} >> (PW - M);
  localparam logic [CW-1:0] LAST_IN    = CW'(NW - 1);
  localparam logic [CW-1:0] LAST_OUT   = CW'(2 * NW - 1);

  localparam logic [2:0] S_LOAD   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ZERO   = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [M-1:0]  d_reg;
  logic [M-1:0]  x_reg;
  logic [M-1:0]  y_reg;
  logic          inf;

  logic [PW-1:0] d_pad;
  logic [PW-1:0] d_next;
  logic [PW-1:0] x_pad;
  logic [PW-1:0] y_pad;
  logic [W-1:0]  out_word;
  logic          in_hs;
  logic          out_hs;

  assign in_hs  = (state == S_LOAD) && in_valid;
  assign out_hs = (state == S_UNLOAD) && out_ready;

  // Scalar with the incoming word merged in at position cnt; bits above M-1 dropped.
  always_comb begin
    d_pad = '0;
    d_pad[M-1:0] = d_reg;
    d_next = d_pad;
    for (int k = 0; k < NW; k++) begin
      if (cnt == CW'(k)) d_next[k*W +: W] = in_data;
    end
    d_next = d_next & FIELD_MASK;
  end

  // Output word select: x words first, then y words; padding above M-1 reads as zero.
  always_comb begin
    x_pad = '0;
    y_pad = '0;
    x_pad[M-1:0] = x_reg;
    y_pad[M-1:0] = y_reg;
    out_word = '0;
    for (int k = 0; k < NW; k++) begin
      if (cnt == CW'(k)) out_word = x_pad[k*W +: W];
    end
    for (int k = 0; k < NW; k++) begin
      if (cnt == CW'(k + NW)) out_word = y_pad[k*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
      cnt   <= '0;
      d_reg <= '0;
      x_reg <= '0;
      y_reg <= '0;
      inf   <= 1'b0;
    end else if (clr) begin
      state <= S_LOAD;
      cnt   <= '0;
      d_reg <= '0;
      x_reg <= '0;
      y_reg <= '0;
      inf   <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_hs) begin
            d_reg <= d_next[M-1:0];
            if (cnt == LAST_IN) begin
              cnt   <= '0;
              state <= (d_next[M-1:0] != '0) ? S_START : S_ZERO;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (pm_done) begin
            x_reg <= pm_x;
            y_reg <= pm_y;
            state <= S_UNLOAD;
          end
        end
        // d == 0 is the point at infinity: skip the multiplier and emit zero coordinates.
        S_ZERO: begin
          x_reg <= '0;
          y_reg <= '0;
          inf   <= 1'b1;
          state <= S_UNLOAD;
        end
        S_UNLOAD: begin
          if (out_hs) begin
            if (cnt == LAST_OUT) begin
              cnt   <= '0;
              inf   <= 1'b0;
              state <= S_LOAD;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_UNLOAD);
  assign out_data  = out_valid ? out_word : '0;
  assign out_last  = out_valid && (cnt == LAST_OUT);
  assign out_inf   = out_valid && inf;
  assign busy      = (state != S_LOAD);
  assign pm_start  = (state == S_START);
  assign pm_d      = d_reg;

endmodule

// File: tb/tb_sect_pt_mul_word_if.sv
// Directed bench for sect_pt_mul_word_if with a behavioural point-multiplier model that
// answers a fixed result a set number of cycles after each start pulse.
module tb_sect_pt_mul_word_if;

  localparam int M  = 571;
  localparam int W  = 32;
  localparam int NW = 18;
  localparam int PW = NW * W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_inf;
  logic         busy;
  logic         pm_start;
  logic [M-1:0] pm_d;
  logic         pm_done;
  logic [M-1:0] pm_x;
  logic [M-1:0] pm_y;

  int n_chk  = 0;
  int n_fail = 0;
  int in_hs_cnt  = 0;
  int out_hs_cnt = 0;
  int start_cnt  = 0;

  logic [PW-1:0] xg_pad;
  logic [PW-1:0] yg_pad;
  logic [PW-1:0] fmask;
  logic [M-1:0]  XG;
  logic [M-1:0]  YG;
  logic [W-1:0]  obs [0:2*NW-1];

  int   lat        = 4;
  int   hold       = 1;
  logic model_chk  = 1'b1;
  logic model_done = 1'b0;
  logic model_good = 1'b0;
  logic spur_done  = 1'b0;

  assign pm_done = model_done | spur_done;
  assign pm_x    = model_good ? XG : ~XG;
  assign pm_y    = model_good ? YG : ~YG;

  sect_pt_mul_word_if #(.M(M), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_inf(out_inf), .busy(busy),
    .pm_start(pm_start), .pm_d(pm_d), .pm_done(pm_done), .pm_x(pm_x), .pm_y(pm_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input int i);
    return (i < NW) ? xg_pad[i*W +: W] : yg_pad[(i-NW)*W +: W];
  endfunction

  always @(negedge clk) begin
    if (in_valid && in_ready)   in_hs_cnt  <= in_hs_cnt + 1;
    if (out_valid && out_ready) out_hs_cnt <= out_hs_cnt + 1;
    if (pm_start)               start_cnt  <= start_cnt + 1;
  end

  // Multiplier model: done 'lat' cycles after start, held 'hold' cycles; only the first
  // done cycle carries the true result so any recapture would be visible.
  initial begin
    logic [M-1:0] d_cap;
    forever begin
      @(negedge clk);
      if (pm_start) begin
        d_cap = pm_d;
        repeat (lat) @(negedge clk);
        if (model_chk) chk("pm_d_hold", PW'(pm_d), PW'(d_cap));
        model_done = 1'b1;
        model_good = 1'b1;
        @(negedge clk);
        model_good = 1'b0;
        if (model_chk) chk("valid_lat", PW'(out_valid), PW'(1'b1));
        if (hold > 1) repeat (hold - 1) @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, PW'(in_ready), PW'(1'b1));
    chk({tag, "_busy"}, PW'(busy), PW'(1'b0));
    chk({tag, "_out_valid"}, PW'(out_valid), PW'(1'b0));
    chk({tag, "_out_misc"}, PW'({out_last, out_inf, pm_start, out_data}), PW'(0));
    chk({tag, "_pm_d"}, PW'(pm_d), PW'(0));
  endtask

  task automatic load(input logic [PW-1:0] dw, input int gap, input int nwords);
    int t;
    for (int k = 0; k < nwords; k++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = dw[k*W +: W];
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("in_ready_wait", PW'(in_ready), PW'(1'b1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic unload(input bit zero, input int stall, input string tag);
    int idx = 0;
    int t = 0;
    while (idx < 2*NW && t < 3000) begin
      out_ready = ($urandom_range(99) >= stall);
      @(negedge clk);
      if (out_valid) begin
        chk(tag, PW'({out_inf, out_last, out_data}),
            PW'({zero, (idx == 2*NW-1), (zero ? 32'h0 : exp_word(idx))}));
        if (out_ready) begin
          obs[idx] = out_data;
          idx++;
        end
      end
      @(posedge clk); #1;
      t++;
    end
    out_ready = 1'b0;
    chk({tag, "_count"}, PW'(idx), PW'(2*NW));
  endtask

  task automatic run_op(input logic [PW-1:0] dw, input bit zero, input int gap,
                        input int stall, input string tag);
    int s0, i0, o0;
    s0 = start_cnt; i0 = in_hs_cnt; o0 = out_hs_cnt;
    load(dw, gap, NW);
    @(negedge clk);
    chk({tag, "_start_lat"}, PW'(pm_start), PW'(!zero));
    chk({tag, "_busy"}, PW'({busy, in_ready, out_valid}), PW'(3'b100));
    chk({tag, "_pm_d"}, PW'(pm_d), dw & fmask);
    @(posedge clk); #1;
    if (zero) begin
      @(negedge clk);
      chk({tag, "_zero_lat"}, PW'(out_valid), PW'(1'b1));
      @(posedge clk); #1;
    end
    unload(zero, stall, tag);
    @(negedge clk);
    chk({tag, "_idle"}, PW'({busy, in_ready, out_valid}), PW'(3'b010));
    chk({tag, "_starts"}, PW'(start_cnt - s0), PW'(zero ? 0 : 1));
    chk({tag, "_in_hs"}, PW'(in_hs_cnt - i0), PW'(NW));
    chk({tag, "_out_hs"}, PW'(out_hs_cnt - o0), PW'(2*NW));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [PW-1:0] dw;
    fmask = '0;
    fmask[M-1:0] = '1;
    for (int k = 0; k < NW; k++) begin
      xg_pad[k*W +: W] = (k == 0) ? 32'h8eec2d19 : 32'h01234567 + 32'(k) * 32'h11111111;
      yg_pad[k*W +: W] = (k == 0) ? 32'h1b8ac15b : 32'h89abcdef ^ (32'(k) * 32'h01010101);
    end
    xg_pad = xg_pad & fmask;
    yg_pad = yg_pad & fmask;
    XG = xg_pad[M-1:0];
    YG = yg_pad[M-1:0];

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    reset_checks("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // d = 1
    run_op(PW'(1), 1'b0, 0, 0, "d_one");
    chk("word0", PW'(obs[0]), PW'(32'h8eec2d19));
    chk("word18", PW'(obs[18]), PW'(32'h1b8ac15b));

    // top word all ones: only 27 field bits survive
    dw = '0;
    dw[17*W +: W] = 32'hFFFFFFFF;
    run_op(dw, 1'b0, 0, 0, "top_word");
    chk("pm_d_top", PW'(pm_d[570:544]), PW'(27'h7FFFFFF));
    chk("pm_d_low", PW'(pm_d[543:0]), PW'(0));

    // d = 0: point at infinity
    run_op(PW'(0), 1'b1, 0, 20, "d_zero");

    // random gaps and stalls
    for (int k = 0; k < NW; k++) dw[k*W +: W] = $urandom;
    run_op(dw, 1'b0, 50, 50, "gaps");

    // spurious done in LOAD, done held 3 cycles in WAIT
    spur_done = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("spur_load", PW'({busy, in_ready, pm_start}), PW'(3'b010));
    spur_done = 1'b0;
    @(posedge clk); #1;
    hold = 3;
    run_op(PW'(32'hCAFE0001), 1'b0, 0, 30, "hold3");
    hold = 1;

    // clr in WAIT
    model_chk = 1'b0;
    lat = 15;
    load(PW'(5), 0, NW);
    @(negedge clk);
    @(negedge clk);
    chk("in_wait", PW'({busy, pm_start, out_valid}), PW'(3'b100));
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    reset_checks("clr_wait");
    repeat (25) begin @(posedge clk); #1; end
    model_chk = 1'b1;
    lat = 4;
    run_op(PW'(7), 1'b0, 0, 0, "after_clr_wait");

    // clr mid-UNLOAD
    load(PW'(1), 0, NW);
    repeat (10) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    @(negedge clk);
    chk("mid_unload", PW'({out_valid, out_data}), PW'({1'b1, exp_word(5)}));
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    reset_checks("clr_unload");
    @(posedge clk); #1;
    run_op(PW'(1), 1'b0, 0, 0, "after_clr_unload");

    // async reset mid-LOAD
    for (int k = 0; k < NW; k++) dw[k*W +: W] = 32'h5A5A0000 + 32'(k);
    load(dw, 0, 7);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    reset_checks("rst_load");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(dw, 1'b0, 0, 0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
